// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU issue controller.
// Latency: none (declarations only).
// Backpressure: n/a.
package alu_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    // Major opcodes handled by this controller
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    // Funct7 forms: base encoding and the SUB/SRA alternate
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Funct3 codes
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        READ,
        EXEC,
        WB
    } state_e;

    // Source of ALU operand B
    typedef enum logic {
        OPB_REG,
        OPB_IMM
    } opb_sel_e;

    // Shift immediates carry a 5-bit shamt and a funct7 qualifier
    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == F3_SLL) || (f3 == F3_SR);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction, register-file, ALU and write-back signals of the issue controller.
// Latency: none (wiring only); PERF_CNT_EN adds the performance counter outputs.
// Backpressure: instruction side is valid/ready; everything else is fixed-timing.
interface alu_issue_ctrl_if;
    import alu_ctrl_pkg::*;

    logic [DATA_W-1:0] iInstr;
    logic              iInstrValid;
    logic              oInstrReady;
    logic [ADDR_W-1:0] oRs1Addr;
    logic [ADDR_W-1:0] oRs2Addr;
    logic [DATA_W-1:0] iRs1Data;
    logic [DATA_W-1:0] iRs2Data;
    logic [DATA_W-1:0] oAluA;
    logic [DATA_W-1:0] oAluB;
    logic [2:0]        oAluFunct3;
    logic [6:0]        oAluFunct7;
    logic [DATA_W-1:0] iAluData;
    logic              iAluZero;
    logic              oWbEn;
    logic [ADDR_W-1:0] oWbAddr;
    logic [DATA_W-1:0] oWbData;
    logic              oZeroFlag;
    logic              oIllegal;
    logic              oBusy;
`ifdef PERF_CNT_EN
    logic [31:0]       oRetired;
    logic [15:0]       oIllegalCnt;
`endif

    // Controller side
    modport master (
        input  iInstr, iInstrValid, iRs1Data, iRs2Data, iAluData, iAluZero,
        output oInstrReady, oRs1Addr, oRs2Addr, oAluA, oAluB, oAluFunct3,
        output oAluFunct7, oWbEn, oWbAddr, oWbData, oZeroFlag, oIllegal, oBusy
`ifdef PERF_CNT_EN
        , output oRetired, oIllegalCnt
`endif
    );

    // Fetch / register file / ALU side
    modport slave (
        output iInstr, iInstrValid, iRs1Data, iRs2Data, iAluData, iAluZero,
        input  oInstrReady, oRs1Addr, oRs2Addr, oAluA, oAluB, oAluFunct3,
        input  oAluFunct7, oWbEn, oWbAddr, oWbData, oZeroFlag, oIllegal, oBusy
`ifdef PERF_CNT_EN
        , input oRetired, oIllegalCnt
`endif
    );

endinterface

// File: rtl/alu_instr_decode.sv
// Combinational RV32I OP / OP-IMM field extraction and legality check.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module alu_instr_decode
    import alu_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] instr_i,
    output logic              legal_o,
    output logic [ADDR_W-1:0] rs1_o,
    output logic [ADDR_W-1:0] rs2_o,
    output logic [ADDR_W-1:0] rd_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output opb_sel_e          opb_sel_o,
    output logic [DATA_W-1:0] imm_o
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode   = instr_i[6:0];
    assign f3       = instr_i[14:12];
    assign f7       = instr_i[31:25];
    assign rs1_o    = instr_i[19:15];
    assign rd_o     = instr_i[11:7];
    assign funct3_o = f3;

    // Operand-B source, immediate shaping, funct7 forwarding and legality
    always_comb begin
        legal_o   = 1'b0;
        rs2_o     = '0;
        funct7_o  = F7_BASE;
        opb_sel_o = OPB_REG;
        imm_o     = '0;
        if (opcode == OPC_OP) begin
            rs2_o    = instr_i[24:20];
            funct7_o = f7;
            // The alternate funct7 only exists for SUB and SRA
            legal_o  = (f7 == F7_BASE) ||
                       ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
        end else if (opcode == OPC_OPIMM) begin
            opb_sel_o = OPB_IMM;
            if (is_shift(f3)) begin
                imm_o    = {{(DATA_W-5){1'b0}}, instr_i[24:20]};
                funct7_o = f7;
                legal_o  = (f3 == F3_SLL) ? (f7 == F7_BASE)
                                          : ((f7 == F7_BASE) || (f7 == F7_ALT));
            end else begin
                // funct7 forced to base so ADDI never selects subtract
                imm_o   = {{(DATA_W-12){instr_i[31]}}, instr_i[31:20]};
                legal_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle RV32I OP/OP-IMM issue controller: decode, regfile read, ALU drive, write-back.
// Latency: handshake edge to oWbEn is 4 cycles, one instruction per 5 cycles; PERF_CNT_EN adds retire/illegal counters.
// Backpressure: oInstrReady is high only in IDLE; iInstrValid is ignored while busy.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN   = DATA_W,
    parameter int REG_AW = ADDR_W
) (
    input  logic             iClk,
    input  logic             iRstN,
    alu_issue_ctrl_if.master bus
);

    state_e            state_q, state_d;
    logic              accept;
    logic              illegal;

    logic [XLEN-1:0]   instr_q;
    logic [REG_AW-1:0] rs1_addr_q;
    logic [REG_AW-1:0] rs2_addr_q;
    logic [XLEN-1:0]   alu_a_q;
    logic [XLEN-1:0]   alu_b_q;
    logic [2:0]        funct3_q;
    logic [6:0]        funct7_q;
    logic [REG_AW-1:0] wb_addr_q;
    logic [XLEN-1:0]   wb_data_q;
    logic              zero_q;

    logic [XLEN-1:0]   dec_instr;
    logic              dec_legal;
    logic [REG_AW-1:0] dec_rs1;
    logic [REG_AW-1:0] dec_rs2;
    logic [REG_AW-1:0] dec_rd;
    logic [2:0]        dec_funct3;
    logic [6:0]        dec_funct7;
    opb_sel_e          dec_opb_sel;
    logic [XLEN-1:0]   dec_imm;

    // In IDLE the decoder looks at the incoming word so the register
    // addresses can be latched on the accept edge and be on the port in DECODE.
    assign dec_instr = (state_q == IDLE) ? bus.iInstr : instr_q;

    alu_instr_decode u_decode (
        .instr_i   (dec_instr),
        .legal_o   (dec_legal),
        .rs1_o     (dec_rs1),
        .rs2_o     (dec_rs2),
        .rd_o      (dec_rd),
        .funct3_o  (dec_funct3),
        .funct7_o  (dec_funct7),
        .opb_sel_o (dec_opb_sel),
        .imm_o     (dec_imm)
    );

    // State register
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the accept and illegal strobes
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        illegal = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.iInstrValid) begin
                    accept  = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (!dec_legal) begin
                    illegal = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = READ;
                end
            end
            READ:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: instruction/addresses on accept, ALU operands in READ, result in EXEC
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            instr_q    <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            zero_q     <= 1'b0;
        end else begin
            if (accept) begin
                instr_q    <= bus.iInstr;
                rs1_addr_q <= dec_rs1;
                rs2_addr_q <= dec_rs2;
            end
            if (state_q == READ) begin
                alu_a_q  <= bus.iRs1Data;
                alu_b_q  <= (dec_opb_sel == OPB_REG) ? bus.iRs2Data : dec_imm;
                funct3_q <= dec_funct3;
                funct7_q <= dec_funct7;
            end
            if (state_q == EXEC) begin
                wb_data_q <= bus.iAluData;
                zero_q    <= bus.iAluZero;
                wb_addr_q <= dec_rd;
            end
        end
    end

    assign bus.oInstrReady = (state_q == IDLE);
    assign bus.oBusy       = (state_q != IDLE);
    assign bus.oIllegal    = illegal;
    // Writes to x0 are suppressed but the zero flag is still captured
    assign bus.oWbEn       = (state_q == WB) && (wb_addr_q != '0);
    assign bus.oRs1Addr    = rs1_addr_q;
    assign bus.oRs2Addr    = rs2_addr_q;
    assign bus.oAluA       = alu_a_q;
    assign bus.oAluB       = alu_b_q;
    assign bus.oAluFunct3  = funct3_q;
    assign bus.oAluFunct7  = funct7_q;
    assign bus.oWbAddr     = wb_addr_q;
    assign bus.oWbData     = wb_data_q;
    assign bus.oZeroFlag   = zero_q;

`ifdef PERF_CNT_EN
    logic [31:0] retired_q;
    logic [15:0] illegal_cnt_q;

    // Retired (every WB, including rd=0) and illegal counters, wrapping at all-ones
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            retired_q     <= '0;
            illegal_cnt_q <= '0;
        end else begin
            if (state_q == WB) begin
                retired_q <= retired_q + 32'd1;
            end
            if (illegal) begin
                illegal_cnt_q <= illegal_cnt_q + 16'd1;
            end
        end
    end

    assign bus.oRetired    = retired_q;
    assign bus.oIllegalCnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a register file and ALU model.
// Latency: n/a.
// Backpressure: instruction valid held or pulsed per scenario.
module tb_alu_issue_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl #(.XLEN(32), .REG_AW(5)) dut (
        .iClk  (clk),
        .iRstN (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: data valid the cycle after the address
    logic [31:0] regs [32];
    always @(posedge clk) begin
        bus.iRs1Data <= regs[bus.oRs1Addr];
        bus.iRs2Data <= regs[bus.oRs2Addr];
    end

    // Combinational ALU model
    logic [31:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (bus.oAluFunct3)
            3'b000: alu_res = bus.oAluFunct7[5] ? bus.oAluA - bus.oAluB : bus.oAluA + bus.oAluB;
            3'b001: alu_res = bus.oAluA << bus.oAluB[4:0];
            3'b010: alu_res = {31'b0, $signed(bus.oAluA) < $signed(bus.oAluB)};
            3'b011: alu_res = {31'b0, bus.oAluA < bus.oAluB};
            3'b100: alu_res = bus.oAluA ^ bus.oAluB;
            3'b101: alu_res = bus.oAluFunct7[5] ? 32'($signed(bus.oAluA) >>> bus.oAluB[4:0])
                                                : bus.oAluA >> bus.oAluB[4:0];
            3'b110: alu_res = bus.oAluA | bus.oAluB;
            default: alu_res = bus.oAluA & bus.oAluB;
        endcase
        bus.iAluData = alu_res;
        bus.iAluZero = (alu_res == 32'd0);
    end

    // Snapshot of one instruction's run, filled by run_instr
    logic [4:0]  s_rs1, s_rs2, s_wbaddr;
    logic [31:0] s_a, s_b, s_wbdata;
    logic [2:0]  s_f3;
    logic [6:0]  s_f7;
    logic        s_zero;
    int          wb_cnt, wb_k, ill_cnt, ill_k, rdy_k;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!bus.oInstrReady && guard < 20) begin
            step();
            guard++;
        end
        total++;
        if (bus.oInstrReady !== 1'b1) begin
            bad++;
            $display("FAIL ready_timeout: oInstrReady=%b required 1", bus.oInstrReady);
        end
    endtask

    // Issue one instruction and record what appears on each cycle k after the handshake edge
    task automatic run_instr(input logic [31:0] instr);
        wait_ready();
        bus.iInstr      = instr;
        bus.iInstrValid = 1'b1;
        step();
        bus.iInstrValid = 1'b0;
        wb_cnt = 0; wb_k = 0; ill_cnt = 0; ill_k = 0; rdy_k = 0;
        s_wbaddr = '0; s_wbdata = '0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 1) begin
                s_rs1 = bus.oRs1Addr;
                s_rs2 = bus.oRs2Addr;
            end
            if (k == 3) begin
                s_a  = bus.oAluA;
                s_b  = bus.oAluB;
                s_f3 = bus.oAluFunct3;
                s_f7 = bus.oAluFunct7;
            end
            if (bus.oWbEn) begin
                wb_cnt++;
                wb_k     = k;
                s_wbaddr = bus.oWbAddr;
                s_wbdata = bus.oWbData;
            end
            if (bus.oIllegal) begin
                ill_cnt++;
                ill_k = k;
            end
            if (bus.oInstrReady && rdy_k == 0) rdy_k = k;
            step();
        end
        s_zero = bus.oZeroFlag;
    endtask

    task automatic test_reset();
        logic [31:0] got  [13];
        logic [31:0] want [13];
        string       nm   [13];
        rst_n = 1'b0;
        step();
        step();
        got[0]  = 32'(bus.oInstrReady); want[0]  = 32'd1; nm[0]  = "rst_ready";
        got[1]  = 32'(bus.oBusy);       want[1]  = 32'd0; nm[1]  = "rst_busy";
        got[2]  = 32'(bus.oRs1Addr);    want[2]  = 32'd0; nm[2]  = "rst_rs1";
        got[3]  = 32'(bus.oRs2Addr);    want[3]  = 32'd0; nm[3]  = "rst_rs2";
        got[4]  = bus.oAluA;            want[4]  = 32'd0; nm[4]  = "rst_alua";
        got[5]  = bus.oAluB;            want[5]  = 32'd0; nm[5]  = "rst_alub";
        got[6]  = 32'(bus.oAluFunct3);  want[6]  = 32'd0; nm[6]  = "rst_f3";
        got[7]  = 32'(bus.oAluFunct7);  want[7]  = 32'd0; nm[7]  = "rst_f7";
        got[8]  = 32'(bus.oWbEn);       want[8]  = 32'd0; nm[8]  = "rst_wben";
        got[9]  = 32'(bus.oWbAddr);     want[9]  = 32'd0; nm[9]  = "rst_wbaddr";
        got[10] = bus.oWbData;          want[10] = 32'd0; nm[10] = "rst_wbdata";
        got[11] = 32'(bus.oZeroFlag);   want[11] = 32'd0; nm[11] = "rst_zero";
        got[12] = 32'(bus.oIllegal);    want[12] = 32'd0; nm[12] = "rst_illegal";
        for (int i = 0; i < 13; i++) begin
            total++;
            if (got[i] !== want[i]) begin
                bad++;
                $display("FAIL %s: got %h required %h", nm[i], got[i], want[i]);
            end
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        run_instr(32'h002081B3);
        total++; if (s_rs1 !== 5'd1)      begin bad++; $display("FAIL add_rs1: got %0d required 1", s_rs1); end
        total++; if (s_rs2 !== 5'd2)      begin bad++; $display("FAIL add_rs2: got %0d required 2", s_rs2); end
        total++; if (s_a !== 32'd5)       begin bad++; $display("FAIL add_alua: got %h required 5", s_a); end
        total++; if (s_b !== 32'd7)       begin bad++; $display("FAIL add_alub: got %h required 7", s_b); end
        total++; if (s_f3 !== 3'b000)     begin bad++; $display("FAIL add_f3: got %b required 000", s_f3); end
        total++; if (s_f7 !== 7'h00)      begin bad++; $display("FAIL add_f7: got %h required 00", s_f7); end
        total++; if (wb_cnt !== 1)        begin bad++; $display("FAIL add_wbcnt: got %0d required 1", wb_cnt); end
        total++; if (wb_k !== 4)          begin bad++; $display("FAIL add_latency: got %0d required 4", wb_k); end
        total++; if (s_wbaddr !== 5'd3)   begin bad++; $display("FAIL add_wbaddr: got %0d required 3", s_wbaddr); end
        total++; if (s_wbdata !== 32'd12) begin bad++; $display("FAIL add_wbdata: got %h required c", s_wbdata); end
        total++; if (rdy_k !== 5)         begin bad++; $display("FAIL add_ready_back: got %0d required 5", rdy_k); end
        total++; if (s_zero !== 1'b0)     begin bad++; $display("FAIL add_zero: got %b required 0", s_zero); end
    endtask

    task automatic test_sub();
        regs[1] = 32'd9;
        regs[2] = 32'd9;
        run_instr(32'h402081B3);
        total++; if (s_f7 !== 7'h20)      begin bad++; $display("FAIL sub_f7: got %h required 20", s_f7); end
        total++; if (s_wbdata !== 32'd0)  begin bad++; $display("FAIL sub_wbdata: got %h required 0", s_wbdata); end
        total++; if (s_zero !== 1'b1)     begin bad++; $display("FAIL sub_zero: got %b required 1", s_zero); end
        total++; if (wb_cnt !== 1)        begin bad++; $display("FAIL sub_wbcnt: got %0d required 1", wb_cnt); end
    endtask

    task automatic test_addi();
        run_instr(32'hFFF00293);
        total++; if (s_b !== 32'hFFFFFFFF)      begin bad++; $display("FAIL addi_alub: got %h required ffffffff", s_b); end
        total++; if (s_f7 !== 7'h00)            begin bad++; $display("FAIL addi_f7: got %h required 00", s_f7); end
        total++; if (s_rs2 !== 5'd0)            begin bad++; $display("FAIL addi_rs2: got %0d required 0", s_rs2); end
        total++; if (s_wbaddr !== 5'd5)         begin bad++; $display("FAIL addi_wbaddr: got %0d required 5", s_wbaddr); end
        total++; if (s_wbdata !== 32'hFFFFFFFF) begin bad++; $display("FAIL addi_wbdata: got %h required ffffffff", s_wbdata); end
        total++; if (s_zero !== 1'b0)           begin bad++; $display("FAIL addi_zero: got %b required 0", s_zero); end
    endtask

    task automatic test_srai();
        regs[1] = 32'h80000000;
        run_instr(32'h4040D313);
        total++; if (s_rs1 !== 5'd1)            begin bad++; $display("FAIL srai_rs1: got %0d required 1", s_rs1); end
        total++; if (s_b !== 32'h00000004)      begin bad++; $display("FAIL srai_alub: got %h required 4", s_b); end
        total++; if (s_f3 !== 3'b101)           begin bad++; $display("FAIL srai_f3: got %b required 101", s_f3); end
        total++; if (s_f7 !== 7'h20)            begin bad++; $display("FAIL srai_f7: got %h required 20", s_f7); end
        total++; if (s_wbaddr !== 5'd6)         begin bad++; $display("FAIL srai_wbaddr: got %0d required 6", s_wbaddr); end
        total++; if (s_wbdata !== 32'hF8000000) begin bad++; $display("FAIL srai_wbdata: got %h required f8000000", s_wbdata); end
    endtask

    task automatic test_illegal();
        logic [31:0] vec [3];
        vec[0] = 32'h00000000;   // unknown opcode
        vec[1] = 32'h022081B3;   // OP with funct7=0000001
        vec[2] = 32'h40109093;   // SLLI with funct7=0100000
        for (int i = 0; i < 3; i++) begin
            run_instr(vec[i]);
            total++; if (ill_cnt !== 1) begin bad++; $display("FAIL ill_pulses[%0d]: got %0d required 1", i, ill_cnt); end
            total++; if (ill_k !== 1)   begin bad++; $display("FAIL ill_when[%0d]: got %0d required 1", i, ill_k); end
            total++; if (wb_cnt !== 0)  begin bad++; $display("FAIL ill_wben[%0d]: got %0d required 0", i, wb_cnt); end
            total++; if (rdy_k !== 2)   begin bad++; $display("FAIL ill_idle[%0d]: got %0d required 2", i, rdy_k); end
        end
        // ALU operands still hold the SRAI values
        total++; if (bus.oAluB !== 32'd4)     begin bad++; $display("FAIL ill_hold_alub: got %h required 4", bus.oAluB); end
        total++; if (bus.oAluFunct7 !== 7'h20) begin bad++; $display("FAIL ill_hold_f7: got %h required 20", bus.oAluFunct7); end
    endtask

    task automatic test_slt();
        regs[1] = 32'hFFFFFFFF;
        regs[2] = 32'd1;
        run_instr(32'h0020A233);
        total++; if (s_f3 !== 3'b010)     begin bad++; $display("FAIL slt_f3: got %b required 010", s_f3); end
        total++; if (s_wbaddr !== 5'd4)   begin bad++; $display("FAIL slt_wbaddr: got %0d required 4", s_wbaddr); end
        total++; if (s_wbdata !== 32'd1)  begin bad++; $display("FAIL slt_wbdata: got %h required 1", s_wbdata); end
    endtask

    task automatic test_rd_zero();
        regs[1] = 32'd3;
        regs[2] = 32'hFFFFFFFD;
        run_instr(32'h00208033);
        total++; if (wb_cnt !== 0)          begin bad++; $display("FAIL rd0_wben: got %0d required 0", wb_cnt); end
        total++; if (s_zero !== 1'b1)       begin bad++; $display("FAIL rd0_zero: got %b required 1", s_zero); end
        total++; if (bus.oWbData !== 32'd0) begin bad++; $display("FAIL rd0_wbdata: got %h required 0", bus.oWbData); end
    endtask

    task automatic test_reset_exec();
        int wbs;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        wait_ready();
        bus.iInstr      = 32'h002081B3;
        bus.iInstrValid = 1'b1;
        step();                 // DECODE
        bus.iInstrValid = 1'b0;
        step();                 // READ
        step();                 // EXEC
        total++; if (bus.oBusy !== 1'b1) begin bad++; $display("FAIL rstx_busy: got %b required 1", bus.oBusy); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++; if (bus.oInstrReady !== 1'b1) begin bad++; $display("FAIL rstx_ready: got %b required 1", bus.oInstrReady); end
        total++; if (bus.oAluA !== 32'd0)      begin bad++; $display("FAIL rstx_alua: got %h required 0", bus.oAluA); end
        wbs = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.oWbEn) wbs++;
            step();
        end
        total++; if (wbs !== 0)           begin bad++; $display("FAIL rstx_wben: got %0d required 0", wbs); end
        total++; if (bus.oBusy !== 1'b0)  begin bad++; $display("FAIL rstx_idle: got %b required 0", bus.oBusy); end
    endtask

    task automatic test_back_to_back();
        int wb1, wb2, rdys;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        wait_ready();
        bus.iInstr      = 32'h002081B3;
        bus.iInstrValid = 1'b1;
        step();
        wb1 = 0; wb2 = 0; rdys = 0;
        for (int k = 1; k <= 10; k++) begin
            if (bus.oWbEn) begin
                if (wb1 == 0) wb1 = k;
                else          wb2 = k;
            end
            if (bus.oInstrReady) rdys++;
            step();
            if (k == 9) bus.iInstrValid = 1'b0;
        end
        total++; if (wb1 !== 4)  begin bad++; $display("FAIL b2b_first_wb: got %0d required 4", wb1); end
        total++; if (wb2 !== 9)  begin bad++; $display("FAIL b2b_second_wb: got %0d required 9", wb2); end
        total++; if (rdys !== 2) begin bad++; $display("FAIL b2b_ready_cycles: got %0d required 2", rdys); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.iInstr      = '0;
        bus.iInstrValid = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        test_reset();
        test_add();
        test_sub();
        test_addi();
        test_srai();
        test_illegal();
        test_slt();
        test_rd_zero();
        test_reset_exec();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
